// File: rtl/oldland_exception_ctrl.sv
// Oldland exception/IRQ entry sequencer. It synchronises and masks IRQs, prioritises causes,
// drains memory, strobes execute-stage entry, then redirects. Optional macro: OLDLAND_IRQ_LATCH_EN.

module oldland_exception_ctrl #(
  parameter int NUM_IRQS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQS-1:0] irq_in,
  input  logic                irq_mask_wr_en,
  input  logic [NUM_IRQS-1:0] irq_mask_wr_val,
`ifdef OLDLAND_IRQ_LATCH_EN
  input  logic                irq_clr_en,
  input  logic [NUM_IRQS-1:0] irq_clr_val,
`endif
  output logic [NUM_IRQS-1:0] irq_mask,
  output logic [NUM_IRQS-1:0] irq_status,
  input  logic                irqs_enabled,
  input  logic                data_abort,
  input  logic                illegal_instr,
  input  logic                exec_i_valid,
  input  logic [31:0]         exec_pc_plus_4,
  input  logic                mem_busy,
  input  logic [25:0]         vector_base,
  output logic                stall,
  output logic                flush,
  output logic                exception_start,
  output logic                irq_start,
  output logic                exception_disable_irqs,
  output logic [31:0]         irq_fault_address,
  output logic                vector_valid,
  output logic [31:0]         vector_addr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ENTER  = 2'd2,
    ST_VECTOR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_DABT = 2'd1,
    CAUSE_ILL  = 2'd2,
    CAUSE_IRQ  = 2'd3
  } cause_t;

  function automatic logic [31:0] vector_offset(input cause_t c);
    case (c)
      CAUSE_DABT: vector_offset = 32'h0000_0014;
      CAUSE_ILL:  vector_offset = 32'h0000_0004;
      CAUSE_IRQ:  vector_offset = 32'h0000_000C;
      default:    vector_offset = 32'h0000_0000;
    endcase
  endfunction

  logic [NUM_IRQS-1:0] irq_sync1_r;
  logic [NUM_IRQS-1:0] irq_sync2_r;
  logic [NUM_IRQS-1:0] mask_next;
  logic [NUM_IRQS-1:0] irq_src;
  logic                irq_pending;
  state_t              state_r;
  cause_t              cause_r;
  cause_t              idle_cause;
  cause_t              drain_cause;
  logic [31:0]         fault_r;
  logic [31:0]         idle_fault;

  // A mask write is folded in before registering so it shows on irq_status next cycle.
  always_comb begin
    if (irq_mask_wr_en) begin
      mask_next = irq_mask_wr_val;
    end else begin
      mask_next = irq_mask;
    end
  end

`ifdef OLDLAND_IRQ_LATCH_EN
  logic [NUM_IRQS-1:0] irq_prev_r;
  logic [NUM_IRQS-1:0] irq_pend_r;
  logic [NUM_IRQS-1:0] irq_clr;

  // Sticky pending bits: a rising synchronised edge sets, write-1 clears, set beats clear.
  always_comb begin
    if (irq_clr_en) begin
      irq_clr = irq_clr_val;
    end else begin
      irq_clr = '0;
    end
    irq_src = (irq_pend_r & ~irq_clr) | (irq_sync2_r & ~irq_prev_r);
  end

  // Edge-history and pending registers for the latched IRQ mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_r <= '0;
      irq_pend_r <= '0;
    end else begin
      irq_prev_r <= irq_sync2_r;
      irq_pend_r <= irq_src;
    end
  end
`else
  // Level-sensitive IRQ lines go straight to the masking stage.
  always_comb begin
    irq_src = irq_sync2_r;
  end
`endif

  // Two-flop synchroniser, mask register and registered masked status.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_sync1_r <= '0;
      irq_sync2_r <= '0;
      irq_mask    <= '1;
      irq_status  <= '0;
    end else begin
      irq_sync1_r <= irq_in;
      irq_sync2_r <= irq_sync1_r;
      irq_mask    <= mask_next;
      irq_status  <= irq_src & ~mask_next;
    end
  end

  assign irq_pending = |irq_status;

  // Cause selection: data abort beats illegal instruction beats IRQ; only abort upgrades in DRAIN.
  always_comb begin
    if (data_abort) begin
      idle_cause = CAUSE_DABT;
    end else if (illegal_instr && exec_i_valid) begin
      idle_cause = CAUSE_ILL;
    end else if (irq_pending && irqs_enabled && exec_i_valid) begin
      idle_cause = CAUSE_IRQ;
    end else begin
      idle_cause = CAUSE_NONE;
    end
    if (data_abort) begin
      drain_cause = CAUSE_DABT;
    end else begin
      drain_cause = cause_r;
    end
    // An interrupted instruction has not executed, so its own PC is the return address.
    if (idle_cause == CAUSE_IRQ) begin
      idle_fault = exec_pc_plus_4 - 32'd4;
    end else begin
      idle_fault = exec_pc_plus_4;
    end
  end

  // Entry sequencer with registered stall/flush/strobe/redirect outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r                <= ST_IDLE;
      cause_r                <= CAUSE_NONE;
      fault_r                <= 32'd0;
      stall                  <= 1'b0;
      flush                  <= 1'b0;
      exception_start        <= 1'b0;
      irq_start              <= 1'b0;
      exception_disable_irqs <= 1'b0;
      irq_fault_address      <= 32'd0;
      vector_valid           <= 1'b0;
      vector_addr            <= 32'd0;
    end else begin
      flush                  <= 1'b0;
      exception_start        <= 1'b0;
      irq_start              <= 1'b0;
      exception_disable_irqs <= 1'b0;
      vector_valid           <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (idle_cause != CAUSE_NONE) begin
            state_r <= ST_DRAIN;
            cause_r <= idle_cause;
            fault_r <= idle_fault;
            stall   <= 1'b1;
            flush   <= 1'b1;
          end else begin
            stall   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          cause_r <= drain_cause;
          stall   <= 1'b1;
          if (!mem_busy) begin
            state_r                <= ST_ENTER;
            exception_disable_irqs <= 1'b1;
            irq_fault_address      <= fault_r;
            if (drain_cause == CAUSE_IRQ) begin
              irq_start       <= 1'b1;
            end else begin
              exception_start <= 1'b1;
            end
          end
        end
        ST_ENTER: begin
          state_r      <= ST_VECTOR;
          stall        <= 1'b0;
          vector_valid <= 1'b1;
          vector_addr  <= {vector_base, 6'b00_0000} | vector_offset(cause_r);
        end
        ST_VECTOR: begin
          state_r <= ST_IDLE;
          stall   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          stall   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_exception_ctrl.sv
// Self-checking bench for oldland_exception_ctrl: a schedule-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.

module tb_oldland_exception_ctrl;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic          irq_mask_wr_en = 1'b0;
  logic [N-1:0]  irq_mask_wr_val = '0;
  logic          irq_clr_en = 1'b0;
  logic [N-1:0]  irq_clr_val = '0;
  logic [N-1:0]  irq_mask, irq_status;
  logic          irqs_enabled = 1'b0, data_abort = 1'b0, illegal_instr = 1'b0;
  logic          exec_i_valid = 1'b0, mem_busy = 1'b0;
  logic [31:0]   exec_pc_plus_4 = 32'd0;
  logic [25:0]   vector_base = 26'd0;
  logic          stall, flush, exception_start, irq_start, exception_disable_irqs, vector_valid;
  logic [31:0]   irq_fault_address, vector_addr;

  oldland_exception_ctrl #(.NUM_IRQS(N)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in),
    .irq_mask_wr_en(irq_mask_wr_en), .irq_mask_wr_val(irq_mask_wr_val),
`ifdef OLDLAND_IRQ_LATCH_EN
    .irq_clr_en(irq_clr_en), .irq_clr_val(irq_clr_val),
`endif
    .irq_mask(irq_mask), .irq_status(irq_status), .irqs_enabled(irqs_enabled),
    .data_abort(data_abort), .illegal_instr(illegal_instr), .exec_i_valid(exec_i_valid),
    .exec_pc_plus_4(exec_pc_plus_4), .mem_busy(mem_busy), .vector_base(vector_base),
    .stall(stall), .flush(flush), .exception_start(exception_start), .irq_start(irq_start),
    .exception_disable_irqs(exception_disable_irqs), .irq_fault_address(irq_fault_address),
    .vector_valid(vector_valid), .vector_addr(vector_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A trap is a record on an absolute cycle timeline: accepted in cycle tr_accept, entry strobes
  // in cycle tr_enter (unknown until memory goes quiet), redirect in tr_enter+1.
  bit            model_on = 1'b0;
  int            e = 0;
  logic [N-1:0]  hist[$];
  logic [N-1:0]  mask_m, status_m, pend_m;
  bit            tr_active = 1'b0, tr_irq = 1'b0;
  int            tr_accept = 0, tr_enter = -1;
  logic [31:0]   tr_off, tr_fault, fault_m, vaddr_m;
  bit            x_stall, x_flush, x_es, x_is, x_dis, x_vv;

  task automatic begin_trap(input int c, input logic [31:0] off, input bit is_irq,
                            input logic [31:0] fa);
    tr_active = 1'b1; tr_accept = c; tr_enter = -1;
    tr_off = off; tr_irq = is_irq; tr_fault = fa;
  endtask

  task automatic model_step();
    int c;
    logic [N-1:0] dly, dly_prev, clr;
    e++;
    c = e - 1;
    if (rst) begin
      model_on = 1'b1;
      mask_m = '1; status_m = '0; pend_m = '0;
      hist.delete();
      for (int k = 0; k < 4; k++) hist.push_back('0);
      tr_active = 1'b0; fault_m = 32'd0; vaddr_m = 32'd0;
    end else begin
      if (tr_active && tr_enter >= 0 && c >= tr_enter + 2) tr_active = 1'b0;
      if (!tr_active) begin
        if (data_abort) begin_trap(c, 32'h14, 1'b0, exec_pc_plus_4);
        else if (illegal_instr && exec_i_valid) begin_trap(c, 32'h04, 1'b0, exec_pc_plus_4);
        else if ((status_m != '0) && irqs_enabled && exec_i_valid)
          begin_trap(c, 32'h0C, 1'b1, exec_pc_plus_4 - 32'd4);
      end else if (tr_enter < 0) begin
        if (data_abort) begin tr_off = 32'h14; tr_irq = 1'b0; end
        if (!mem_busy) begin tr_enter = e; fault_m = tr_fault; end
      end else if (c == tr_enter) begin
        vaddr_m = {vector_base, 6'd0} | tr_off;
      end
      if (irq_mask_wr_en) mask_m = irq_mask_wr_val;
      // Status reflects the line as sampled two edges earlier.
      hist.push_back(irq_in);
      dly = hist[hist.size()-3];
      dly_prev = hist[hist.size()-4];
`ifdef OLDLAND_IRQ_LATCH_EN
      clr = irq_clr_en ? irq_clr_val : '0;
      pend_m = (pend_m & ~clr) | (dly & ~dly_prev);
      status_m = pend_m & ~mask_m;
`else
      clr = '0;
      status_m = (dly | clr) & ~mask_m;
`endif
    end
    x_flush = tr_active && (e == tr_accept + 1);
    x_stall = tr_active && (e > tr_accept) && (tr_enter < 0 || e <= tr_enter);
    x_es    = tr_active && (e == tr_enter) && !tr_irq;
    x_is    = tr_active && (e == tr_enter) && tr_irq;
    x_dis   = tr_active && (e == tr_enter);
    x_vv    = tr_active && (tr_enter >= 0) && (e == tr_enter + 1);
  endtask

  task automatic compare();
    check("stall", {31'd0, stall}, {31'd0, x_stall});
    check("flush", {31'd0, flush}, {31'd0, x_flush});
    check("exception_start", {31'd0, exception_start}, {31'd0, x_es});
    check("irq_start", {31'd0, irq_start}, {31'd0, x_is});
    check("exception_disable_irqs", {31'd0, exception_disable_irqs}, {31'd0, x_dis});
    check("vector_valid", {31'd0, vector_valid}, {31'd0, x_vv});
    check("irq_fault_address", irq_fault_address, fault_m);
    check("irq_mask", {24'd0, irq_mask}, {24'd0, mask_m});
    check("irq_status", {24'd0, irq_status}, {24'd0, status_m});
    if (x_vv) check("vector_addr", vector_addr, vaddr_m);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (model_on) compare();
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mask_write(input logic [N-1:0] v);
    irq_mask_wr_en = 1'b1; irq_mask_wr_val = v;
    tick(1);
    irq_mask_wr_en = 1'b0;
  endtask

  task automatic clear_pending();
`ifdef OLDLAND_IRQ_LATCH_EN
    irq_clr_en = 1'b1; irq_clr_val = '1;
    tick(1);
    irq_clr_en = 1'b0;
`else
    tick(1);
`endif
  endtask

  // Follows one trap to its redirect; drops IRQ enable and abort on the redirect cycle.
  task automatic run_trap(input int budget, output bit got_es, output bit got_is,
                          output logic [31:0] fa, output logic [31:0] va, output int stalls);
    bit done;
    done = 1'b0; got_es = 1'b0; got_is = 1'b0; fa = 32'hDEAD; va = 32'hDEAD; stalls = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (exception_start) begin got_es = 1'b1; fa = irq_fault_address; end
      if (irq_start) begin got_is = 1'b1; fa = irq_fault_address; end
      if (vector_valid) begin
        va = vector_addr; done = 1'b1;
        irqs_enabled = 1'b0; data_abort = 1'b0;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL trap_timeout: no vector_valid within %0d cycles", budget);
    end
  endtask

  task automatic quiet_cycles(input int n, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (stall || flush || vector_valid) stalls++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bit es, is;
    logic [31:0] fa, va;
    int st, st2, s_cyc, i_cyc, gap;

    tick(3);
    rst = 1'b0;
    check("reset_mask", {24'd0, irq_mask}, 32'h0000_00FF);
    check("reset_vector_addr", vector_addr, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);

    // IRQ entry, base 0x40
    mask_write('0);
    exec_i_valid = 1'b1; irqs_enabled = 1'b1; exec_pc_plus_4 = 32'h1008;
    vector_base = 26'h40; irq_in = 8'h01;
    s_cyc = -100; i_cyc = -1; fa = 32'hDEAD; va = 32'hDEAD;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_cyc < 0 && irq_status != '0) s_cyc = i;
      if (irq_start && i_cyc < 0) begin i_cyc = i; fa = irq_fault_address; end
      if (vector_valid) begin va = vector_addr; irqs_enabled = 1'b0; break; end
    end
    check("t1_status_to_irq_start", i_cyc - s_cyc, 32'd2);
    check("t1_fault_address", fa, 32'h0000_1004);
    check("t1_vector_addr", va, 32'h0000_100C);
    irq_in = '0; tick(6); clear_pending();

    // Masked or globally disabled IRQ must not trap
    mask_write(8'h04); irq_in = 8'h04; irqs_enabled = 1'b1; exec_pc_plus_4 = 32'h3000;
    quiet_cycles(8, st);
    check("t2_masked_no_trap", st, 32'd0);
    check("t2_masked_status", {24'd0, irq_status}, 32'd0);
    irqs_enabled = 1'b0;
    mask_write('0);
    quiet_cycles(5, st);
    check("t2_disabled_no_trap", st, 32'd0);
    check("t2_unmasked_status", {24'd0, irq_status}, 32'h0000_0004);
    mask_write(8'h04); tick(3); irqs_enabled = 1'b1;
    irq_mask_wr_en = 1'b1; irq_mask_wr_val = '0;
    s_cyc = -100; i_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      irq_mask_wr_en = 1'b0;
      if (s_cyc < 0 && irq_status == 8'h04) s_cyc = i;
      if (irq_start && i_cyc < 0) begin i_cyc = i; fa = irq_fault_address; end
      if (vector_valid) begin irqs_enabled = 1'b0; break; end
    end
    check("t2_unmask_to_irq_start", i_cyc - s_cyc, 32'd2);
    check("t2_fault_address", fa, 32'h0000_2FFC);
    irq_in = '0; tick(6); clear_pending();

    // Data abort beats a simultaneous IRQ
    irq_in = 8'h01; tick(5);
    exec_pc_plus_4 = 32'h2000; vector_base = 26'd0; irqs_enabled = 1'b1; data_abort = 1'b1;
    run_trap(20, es, is, fa, va, st);
    check("t3_exception_start", {30'd0, es, is}, 32'h0000_0002);
    check("t3_fault_address", fa, 32'h0000_2000);
    check("t3_vector_addr", va, 32'h0000_0014);
    irq_in = '0; tick(6); clear_pending();

    // Illegal instruction needs exec_i_valid; held cause re-traps right after the redirect
    illegal_instr = 1'b1; exec_i_valid = 1'b0;
    quiet_cycles(4, st);
    check("t4_illegal_invalid_no_trap", st, 32'd0);
    exec_pc_plus_4 = 32'h500; vector_base = 26'd1; exec_i_valid = 1'b1;
    run_trap(20, es, is, fa, va, st);
    check("t4_ill_strobes", {30'd0, es, is}, 32'h0000_0002);
    check("t4_ill_fault_address", fa, 32'h0000_0500);
    check("t4_ill_vector_addr", va, 32'h0000_0044);
    gap = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (flush) begin gap = i; break; end
    end
    check("t4_back_to_back_gap", gap, 32'd2);
    illegal_instr = 1'b0;
    run_trap(20, es, is, fa, va, st);
    check("t4_second_vector_addr", va, 32'h0000_0044);
    tick(4);

    // mem_busy holds DRAIN for five extra cycles
    irq_in = 8'h02; tick(5);
    exec_pc_plus_4 = 32'h1008; vector_base = 26'h40; irqs_enabled = 1'b1; mem_busy = 1'b1;
    st2 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stall) st2++;
    end
    mem_busy = 1'b0;
    run_trap(20, es, is, fa, va, st);
    check("t5_stall_cycles", st + st2, 32'd7);
    check("t5_irq_strobes", {30'd0, es, is}, 32'h0000_0001);
    check("t5_vector_addr", va, 32'h0000_100C);

    // Data abort during DRAIN upgrades the cause, keeps the IRQ return address
    irqs_enabled = 1'b1; mem_busy = 1'b1;
    tick(3);
    data_abort = 1'b1; tick(1); data_abort = 1'b0; mem_busy = 1'b0;
    run_trap(20, es, is, fa, va, st);
    check("t6_upgraded_strobes", {30'd0, es, is}, 32'h0000_0002);
    check("t6_fault_address", fa, 32'h0000_1004);
    check("t6_vector_addr", va, 32'h0000_1014);
    irq_in = '0; tick(6); clear_pending();

    // Reset in DRAIN aborts with no redirect
    irq_in = 8'h08; tick(5);
    irqs_enabled = 1'b1; mem_busy = 1'b1;
    tick(2);
    check("t7_in_drain_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1; tick(1);
    check("t7_rst_stall_flush", {30'd0, stall, flush}, 32'd0);
    check("t7_rst_strobes", {28'd0, exception_start, irq_start, exception_disable_irqs, vector_valid}, 32'd0);
    check("t7_rst_fault_address", irq_fault_address, 32'd0);
    check("t7_rst_vector_addr", vector_addr, 32'd0);
    check("t7_rst_mask", {24'd0, irq_mask}, 32'h0000_00FF);
    check("t7_rst_status", {24'd0, irq_status}, 32'd0);
    rst = 1'b0; mem_busy = 1'b0;
    quiet_cycles(8, st);
    check("t7_no_vector_after_rst", st, 32'd0);
    irq_in = '0; irqs_enabled = 1'b0; tick(4);

`ifdef OLDLAND_IRQ_LATCH_EN
    // A one-cycle pulse stays pending until cleared
    clear_pending();
    mask_write('0);
    irq_in = 8'h10; tick(1); irq_in = '0;
    tick(6);
    check("t8_latched_status", {24'd0, irq_status}, 32'h0000_0010);
    tick(5);
    check("t8_still_latched", {24'd0, irq_status}, 32'h0000_0010);
    irq_clr_en = 1'b1; irq_clr_val = 8'h10; tick(1); irq_clr_en = 1'b0;
    check("t8_cleared_status", {24'd0, irq_status}, 32'd0);
    tick(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oldland_exception_ctrl.md
Name: oldland_exception_ctrl

Overview:
Sequences exception and interrupt entry around the execute stage. It synchronises and masks external IRQ lines and prioritises data abort, illegal instruction and IRQ causes. It stalls and flushes the pipeline until memory is quiescent, then pulses the execute-stage entry strobes (exception_start, irq_start, exception_disable_irqs, irq_fault_address). Finally it issues the redirect to the exception vector. SWI and RFE remain handled by execute itself.

Parameters:
NUM_IRQS, 8, number of external interrupt lines (1..32)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
irq_in  in  NUM_IRQS  asynchronous level-high interrupt requests
irq_mask_wr_en  in  1  write strobe for mask register
irq_mask_wr_val  in  NUM_IRQS  new mask value (1 = masked)
irq_mask  out  NUM_IRQS  current mask
irq_status  out  NUM_IRQS  synchronised, unmasked pending lines
irqs_enabled  in  1  global IRQ enable from execute PSR
data_abort  in  1  data abort from memory stage
illegal_instr  in  1  decoded illegal instruction reaching execute
exec_i_valid  in  1  execute holds a valid instruction
exec_pc_plus_4  in  32  PC+4 of instruction in execute
mem_busy  in  1  memory access outstanding
vector_base  in  26  exception table base from execute (CR0[31:6])
stall  out  1  hold fetch/decode/execute
flush  out  1  kill instruction in execute and younger
exception_start  out  1  one-cycle entry strobe (abort/illegal)
irq_start  out  1  one-cycle entry strobe (IRQ)
exception_disable_irqs  out  1  one-cycle strobe clearing irqs_enabled
irq_fault_address  out  32  return address for RFE
vector_valid  out  1  one-cycle redirect strobe
vector_addr  out  32  redirect target

Behaviour:
- Reset values:
  - irq_mask all ones.
  - All other outputs 0, including irq_fault_address, vector_addr and irq_status.
  - Synchroniser flops cleared; state IDLE.
  - Reset mid-sequence aborts to IDLE in the same edge; no strobe is emitted.
- IRQ path:
  - irq_in passes a 2-flop synchroniser per bit.
  - irq_status = sync & ~irq_mask, registered (3 cycles irq_in->irq_status).
  - irq_pending = |irq_status.
  - A mask write takes effect on irq_status the following cycle.
- Cause priority in IDLE, evaluated each cycle:
  - data_abort (cause DABT, vector offset 0x14).
  - illegal_instr && exec_i_valid (cause ILL, offset 0x04).
  - irq_pending && irqs_enabled && exec_i_valid (cause IRQ, offset 0x0C).
  - None: stay IDLE.
- Fault address latched on IDLE exit:
  - IRQ: exec_pc_plus_4 - 4 (interrupted instruction re-executes).
  - ILL, DABT: exec_pc_plus_4.
- States:
  - IDLE -> DRAIN on any cause. flush=1 for exactly the first DRAIN cycle; stall=1 throughout DRAIN and ENTER.
  - DRAIN: stays while mem_busy. data_abort arriving in DRAIN upgrades cause to DABT (fault address unchanged). Falling irq lines do not cancel a committed IRQ entry. Exits to ENTER when !mem_busy.
  - ENTER: one cycle.
    - exception_disable_irqs=1.
    - irq_start=1 if cause IRQ, else exception_start=1.
    - irq_fault_address valid this cycle and held after. -> VECTOR.
  - VECTOR: one cycle. vector_valid=1, vector_addr={vector_base,6'b0}|offset, stall=0. -> IDLE.
- Minimum latency: cause in IDLE (cycle 0) -> ENTER at cycle 2 -> vector_valid at cycle 3.
- Causes seen in ENTER/VECTOR are ignored. The handler re-traps them once back in IDLE if they are still asserted.
- Back-to-back: a new cause may be accepted in the cycle after VECTOR.

Optional Feature:
OLDLAND_IRQ_LATCH_EN:
- Defined:
  - Each synchronised line feeds a sticky pending bit, set on rising edge.
  - Adds ports irq_clr_en (1) and irq_clr_val (NUM_IRQS), write-1-to-clear.
  - If set and clear hit the same cycle, set wins.
  - irq_status = pending & ~mask.
- Undefined: level-sensitive as above; clear ports absent.

Test Plan:
- Reset, then irq_in=0x01, mask=0x00, irqs_enabled=1, exec_i_valid=1, exec_pc_plus_4=0x1008, vector_base=0x40 -> irq_start at cycle 2 after irq_status!=0, irq_fault_address=0x1004, vector_valid with vector_addr=0x100C.
- irq_in=0x04 with mask=0x04 or irqs_enabled=0 -> no stall/flush/strobe; clearing mask -> entry within 2 cycles of irq_status=0x04.
- data_abort and IRQ together, exec_pc_plus_4=0x2000, vector_base=0 -> exception_start (not irq_start), irq_fault_address=0x2000, vector_addr=0x14.
- IRQ entry with mem_busy high 5 cycles -> stall held 5 extra cycles, ENTER on first !mem_busy; data_abort during DRAIN -> vector_addr ends 0x14.
- rst asserted in DRAIN -> all outputs 0 next cycle, mask=all ones, no vector_valid.
- With OLDLAND_IRQ_LATCH_EN: 1-cycle-wide irq_in pulse -> irq_status stays set until irq_clr_val bit written.
